// File: rtl/power_pkg.sv
// Shared types and helpers for the shutdown controller: FSM state encoding
// and the counter-width helper used to size every internal counter.
package power_pkg;

   typedef enum logic [1:0] {
      ST_POWER_UP = 2'b00,
      ST_ON       = 2'b01,
      ST_TRIPPED  = 2'b10
   } state_t;

   // Bits needed to hold values 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/fault_debounce.sv
// Per-fault debouncer: saturating count of consecutive high samples; deb_o is
// asserted once DEBOUNCE_CYCLES high samples have been seen back to back.
module fault_debounce
   import power_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic fault_i,
   output logic deb_o
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (fault_i) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign deb_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/shutdown_controller.sv
// Rail shutdown sequencer: trips all rails off on a debounced fault and
// re-enables them one at a time. Optional AUTO_RESTART_EN macro adds a
// fault-free timeout that leaves TRIPPED without an operator clear.
module shutdown_controller
   import power_pkg::*;
#(
   parameter int NUM_FAULTS      = 2,
   parameter int NUM_RAILS       = 4,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int STAGGER_CYCLES  = 5000,
   parameter int RESTART_CYCLES  = 50000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_FAULTS-1:0] fault_in,
   input  logic [NUM_FAULTS-1:0] fault_mask,
   input  logic                  clear,
   output logic [NUM_RAILS-1:0]  shutdown,
   output logic                  all_on,
   output logic [NUM_FAULTS-1:0] fault_latched,
   output state_t                state
);

   localparam int SW = cnt_width(STAGGER_CYCLES - 1);
   localparam int IW = cnt_width(NUM_RAILS - 1);
   localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_RAILS - 1);

   if (DEBOUNCE_CYCLES < 1 || STAGGER_CYCLES < 1 || RESTART_CYCLES < 1) begin : g_bad_param
      $error("shutdown_controller: cycle parameters must be >= 1");
   end

   state_t                state_q, state_d;
   logic [SW-1:0]         stag_q, stag_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_RAILS-1:0]  shutdown_q, shutdown_d;
   logic [NUM_FAULTS-1:0] latched_q, latched_d;
   logic [NUM_FAULTS-1:0] deb, active;
   logic                  any_active;
   logic                  restart_due;

   for (genvar i = 0; i < NUM_FAULTS; i++) begin : g_deb
      fault_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk     (clk),
         .reset_n (reset_n),
         .fault_i (fault_in[i]),
         .deb_o   (deb[i])
      );
   end

   assign active     = deb & ~fault_mask;
   assign any_active = |active;

`ifdef AUTO_RESTART_EN
   localparam int RW = cnt_width(RESTART_CYCLES - 1);
   localparam logic [RW-1:0] RST_LAST = RW'(RESTART_CYCLES - 1);

   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic          any_deb;

   // Masked faults still hold off auto-restart: any debounced level counts.
   assign any_deb     = |deb;
   assign restart_due = (rst_cnt_q == RST_LAST) && !any_deb;

   always_comb begin
      rst_cnt_d = '0;
      if (state_q == ST_TRIPPED && !any_deb) begin
         rst_cnt_d = rst_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rst_cnt_q <= '0;
      end else begin
         rst_cnt_q <= rst_cnt_d;
      end
   end
`else
   assign restart_due = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      stag_d     = stag_q;
      idx_d      = idx_q;
      shutdown_d = shutdown_q;
      latched_d  = latched_q;
      case (state_q)
         ST_POWER_UP, ST_ON: begin
            if (any_active) begin
               state_d    = ST_TRIPPED;
               shutdown_d = '1;
               latched_d  = latched_q | active;
               stag_d     = '0;
               idx_d      = '0;
            end else if (state_q == ST_ON) begin
               shutdown_d = '0;
            end else if (stag_q == STAG_LAST) begin
               stag_d = '0;
               idx_d  = idx_q + 1'b1;
               for (int k = 0; k < NUM_RAILS; k++) begin
                  if (k == int'(idx_q)) shutdown_d[k] = 1'b0;
               end
               if (idx_q == IDX_LAST) begin
                  state_d = ST_ON;
                  idx_d   = '0;
               end
            end else begin
               stag_d = stag_q + 1'b1;
            end
         end
         ST_TRIPPED: begin
            shutdown_d = '1;
            latched_d  = latched_q | active;
            // A clear only counts when nothing is still actively faulting.
            if (clear && !any_active) begin
               state_d   = ST_POWER_UP;
               stag_d    = '0;
               idx_d     = '0;
               latched_d = '0;
            end else if (restart_due) begin
               state_d = ST_POWER_UP;
               stag_d  = '0;
               idx_d   = '0;
            end
         end
         default: begin
            state_d    = ST_TRIPPED;
            shutdown_d = '1;
            stag_d     = '0;
            idx_d      = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_POWER_UP;
         stag_q     <= '0;
         idx_q      <= '0;
         shutdown_q <= '1;
         latched_q  <= '0;
      end else begin
         state_q    <= state_d;
         stag_q     <= stag_d;
         idx_q      <= idx_d;
         shutdown_q <= shutdown_d;
         latched_q  <= latched_d;
      end
   end

   assign shutdown      = shutdown_q;
   assign all_on        = (state_q == ST_ON);
   assign fault_latched = latched_q;
   assign state         = state_q;

endmodule

// File: tb/tb_shutdown_controller.sv
// Bench for shutdown_controller: scripted scenarios with an expected-trace
// queue of {state, all_on, shutdown}; AUTO_RESTART_EN selects the restart case.
module tb_shutdown_controller;
   import power_pkg::*;

   localparam int NF  = 2;
   localparam int NR  = 3;
   localparam int DEB = 4;
   localparam int STG = 8;
   localparam int RST = 16;
   localparam int W   = 2 + 1 + NR;

   logic          clk;
   logic          reset_n;
   logic [NF-1:0] fault_in;
   logic [NF-1:0] fault_mask;
   logic          clear;
   logic [NR-1:0] shutdown;
   logic          all_on;
   logic [NF-1:0] fault_latched;
   state_t        state;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  exp_v;
   logic [W-1:0]  obs_v;
   int            n_tests;
   int            n_fail;

   shutdown_controller #(
      .NUM_FAULTS      (NF),
      .NUM_RAILS       (NR),
      .DEBOUNCE_CYCLES (DEB),
      .STAGGER_CYCLES  (STG),
      .RESTART_CYCLES  (RST)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .fault_in      (fault_in),
      .fault_mask    (fault_mask),
      .clear         (clear),
      .shutdown      (shutdown),
      .all_on        (all_on),
      .fault_latched (fault_latched),
      .state         (state)
   );

   // ---- clock ----
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---- driver tasks ----
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   function automatic logic [W-1:0] pk(input state_t s, input logic [NR-1:0] sd);
      return {s, (s == ST_ON), sd};
   endfunction

   // Expected power-up trace e edges after entry into POWER_UP.
   function automatic logic [W-1:0] pu_trace(input int e);
      if (e >= 3 * STG) return pk(ST_ON, 3'b000);
      if (e >= 2 * STG) return pk(ST_POWER_UP, 3'b100);
      if (e >= STG)     return pk(ST_POWER_UP, 3'b110);
      return pk(ST_POWER_UP, 3'b111);
   endfunction

   // ---- scenarios ----
   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({state, all_on, shutdown, fault_latched} !== {ST_POWER_UP, 1'b0, 3'b111, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_state got st=%0d on=%b sd=%b fl=%b want st=0 on=0 sd=111 fl=00",
                  state, all_on, shutdown, fault_latched);
      end
      reset_n = 1'b1;
      for (int e = 1; e <= 26; e++) exp_q.push_back(pu_trace(e));
      for (int e = 1; e <= 26; e++) begin
         tick();
         exp_v = exp_q.pop_front();
         obs_v = {state, all_on, shutdown};
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL power_up_seq edge %0d got %b want %b", e, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_trip();
      // 3-cycle glitch then idle: never reaches the debounce threshold
      fault_in = 2'b01;
      for (int e = 1; e <= 10; e++) begin
         if (e == 4) fault_in = 2'b00;
         exp_q.push_back(pk(ST_ON, 3'b000));
         tick();
         exp_v = exp_q.pop_front();
         obs_v = {state, all_on, shutdown};
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL glitch edge %0d got %b want %b", e, obs_v, exp_v);
         end
      end
      fault_in = 2'b01;
      for (int e = 1; e <= 5; e++) begin
         exp_q.push_back((e < DEB + 1) ? pk(ST_ON, 3'b000) : pk(ST_TRIPPED, 3'b111));
         tick();
         exp_v = exp_q.pop_front();
         obs_v = {state, all_on, shutdown};
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL trip_latency edge %0d got %b want %b", e, obs_v, exp_v);
         end
      end
      n_tests++;
      if (fault_latched !== 2'b01) begin
         n_fail++;
         $display("FAIL trip_latched got %b want 01", fault_latched);
      end
   endtask

   task automatic test_clear();
      pulse_clear();
      n_tests++;
      if ({state, shutdown, fault_latched} !== {ST_TRIPPED, 3'b111, 2'b01}) begin
         n_fail++;
         $display("FAIL clear_while_active got st=%0d sd=%b fl=%b want st=2 sd=111 fl=01",
                  state, shutdown, fault_latched);
      end
      fault_in = 2'b00;
      tick();
      pulse_clear();
      n_tests++;
      if ({state, shutdown, fault_latched} !== {ST_POWER_UP, 3'b111, 2'b00}) begin
         n_fail++;
         $display("FAIL clear_accepted got st=%0d sd=%b fl=%b want st=0 sd=111 fl=00",
                  state, shutdown, fault_latched);
      end
      for (int e = 1; e <= 24; e++) exp_q.push_back(pu_trace(e));
      for (int e = 1; e <= 24; e++) begin
         tick();
         exp_v = exp_q.pop_front();
         obs_v = {state, all_on, shutdown};
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL restart_seq edge %0d got %b want %b", e, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_mask();
      fault_mask = 2'b01;
      fault_in   = 2'b01;
      for (int e = 1; e <= 20; e++) begin
         exp_q.push_back(pk(ST_ON, 3'b000));
         tick();
         exp_v = exp_q.pop_front();
         obs_v = {state, all_on, shutdown};
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL masked_fault edge %0d got %b want %b", e, obs_v, exp_v);
         end
      end
      fault_mask = 2'b00;
      exp_q.push_back(pk(ST_TRIPPED, 3'b111));
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {state, all_on, shutdown};
      n_tests++;
      if (obs_v !== exp_v || fault_latched !== 2'b01) begin
         n_fail++;
         $display("FAIL unmask_trip got %b fl=%b want %b fl=01", obs_v, fault_latched, exp_v);
      end
      // masking after the trip must not release anything
      fault_mask = 2'b01;
      tick();
      tick();
      n_tests++;
      if ({state, shutdown} !== {ST_TRIPPED, 3'b111}) begin
         n_fail++;
         $display("FAIL mask_after_trip got st=%0d sd=%b want st=2 sd=111", state, shutdown);
      end
      fault_mask = 2'b00;
   endtask

   task automatic test_powerup_trip();
      fault_in = 2'b00;
      tick();
      pulse_clear();
      for (int e = 1; e <= STG; e++) exp_q.push_back(pu_trace(e));
      for (int e = 1; e <= STG; e++) begin
         tick();
         exp_v = exp_q.pop_front();
         obs_v = {state, all_on, shutdown};
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL pu_partial edge %0d got %b want %b", e, obs_v, exp_v);
         end
      end
      // fault on bit 1; clear asserted on the very edge that trips
      fault_in = 2'b10;
      for (int e = 1; e <= 5; e++) begin
         if (e == 5) clear = 1'b1;
         exp_q.push_back((e < 5) ? pk(ST_POWER_UP, 3'b110) : pk(ST_TRIPPED, 3'b111));
         tick();
         exp_v = exp_q.pop_front();
         obs_v = {state, all_on, shutdown};
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL pu_trip_with_clear edge %0d got %b want %b", e, obs_v, exp_v);
         end
      end
      clear = 1'b0;
      n_tests++;
      if (fault_latched !== 2'b10) begin
         n_fail++;
         $display("FAIL pu_trip_latched got %b want 10", fault_latched);
      end
   endtask

   task automatic test_reset_mid();
      reset_n = 1'b0;
      tick();
      n_tests++;
      if ({state, shutdown, fault_latched} !== {ST_POWER_UP, 3'b111, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_mid_trip got st=%0d sd=%b fl=%b want st=0 sd=111 fl=00",
                  state, shutdown, fault_latched);
      end
      fault_in = 2'b00;
      reset_n  = 1'b1;
      for (int e = 1; e <= STG + 2; e++) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int e = 1; e <= 24; e++) exp_q.push_back(pu_trace(e));
      for (int e = 1; e <= 24; e++) begin
         tick();
         exp_v = exp_q.pop_front();
         obs_v = {state, all_on, shutdown};
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid_seq edge %0d got %b want %b", e, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_auto_restart();
      int n_wait;
      fault_in = 2'b01;
      for (int e = 1; e <= DEB + 1; e++) tick();
      fault_in = 2'b00;
      tick();
`ifdef AUTO_RESTART_EN
      n_wait = RST;
      for (int e = 1; e <= n_wait; e++)
         exp_q.push_back((e < RST) ? pk(ST_TRIPPED, 3'b111) : pk(ST_POWER_UP, 3'b111));
`else
      n_wait = 40;
      for (int e = 1; e <= n_wait; e++) exp_q.push_back(pk(ST_TRIPPED, 3'b111));
`endif
      for (int e = 1; e <= n_wait; e++) begin
         tick();
         exp_v = exp_q.pop_front();
         obs_v = {state, all_on, shutdown};
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL auto_restart edge %0d got %b want %b", e, obs_v, exp_v);
         end
      end
      n_tests++;
      if (fault_latched !== 2'b01) begin
         n_fail++;
         $display("FAIL auto_restart_latched got %b want 01", fault_latched);
      end
   endtask

   // ---- sequence and report ----
   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      fault_in   = '0;
      fault_mask = '0;
      clear      = 1'b0;
      test_reset();
      test_trip();
      test_clear();
      test_mask();
      test_powerup_trip();
      test_reset_mid();
      test_auto_restart();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shutdown_controller.md
Name: shutdown_controller

Overview:
Generates the per-rail shutdown requests consumed by the GPIO power-management gates. It debounces external fault inputs and trips every rail off in one cycle when a fault is seen. On restart (reset or operator clear) it re-enables rails one at a time with a fixed stagger, so inrush is spread out. It sits between the fault sources (kill switch, battery-low, overcurrent) and the `shutdown` inputs of the GPIO gating instances.

Parameters:
NUM_FAULTS, 2, number of fault inputs
NUM_RAILS, 4, number of independently sequenced shutdown outputs
DEBOUNCE_CYCLES, 1000, consecutive high samples before a fault is accepted (>=1)
STAGGER_CYCLES, 5000, cycles between successive rail releases (>=1)
RESTART_CYCLES, 50000, fault-free cycles before auto-restart (used only with AUTO_RESTART_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
fault_in  in  NUM_FAULTS  raw fault levels, active high, already synchronised
fault_mask  in  NUM_FAULTS  1 = ignore that fault
clear  in  1  single-cycle pulse; requests restart from TRIPPED
shutdown  out  NUM_RAILS  1 = rail forced off; bit k feeds rail k's gate
all_on  out  1  high only in state ON
fault_latched  out  NUM_FAULTS  sticky record of faults that caused or joined a trip
state  out  2  current FSM state (encoding from package)

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low. With reset_n low at a rising edge:
    - state = POWER_UP
    - shutdown = all ones
    - all_on = 0
    - fault_latched = 0
    - all counters = 0
- Debounce, per fault i:
  - Counter increments on each edge where fault_in[i] = 1 and saturates at DEBOUNCE_CYCLES.
  - Counter clears on any edge where fault_in[i] = 0.
  - deb[i] = (count == DEBOUNCE_CYCLES).
  - active[i] = deb[i] & ~fault_mask[i].
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- FSM states: POWER_UP, ON, TRIPPED. Encoding 00, 01, 10; 11 is illegal and recovers to TRIPPED.
- POWER_UP:
  - Stagger counter runs from 0; rail index starts at 0.
  - When the counter reaches STAGGER_CYCLES-1, shutdown[idx] clears, idx increments and the counter wraps to 0.
  - Net effect: rail k is released STAGGER_CYCLES*(k+1) edges after POWER_UP entry.
  - The edge that releases rail NUM_RAILS-1 also moves the FSM to ON.
  - Already-released rails stay released.
- ON:
  - shutdown = 0 and all_on = 1.
- Trip:
  - In POWER_UP or ON, any active[i] at an edge sends the FSM to TRIPPED on that edge.
  - On the same edge: shutdown = all ones, all_on = 0, and fault_latched |= active.
  - Net latency: shutdown rises on the (DEBOUNCE_CYCLES+1)th edge after fault_in is first sampled high.
- TRIPPED:
  - shutdown stays all ones.
  - fault_latched continues to OR in active.
  - clear with no active[i] → POWER_UP with counters zeroed, and fault_latched cleared.
  - clear while any active[i] is high is ignored and has no effect.
- Boundary conditions:
  - clear outside TRIPPED is ignored.
  - Trip and clear on the same edge: trip wins.
  - Masking a fault after a trip does not un-trip; only clear does.
  - Unmasking an already-debounced fault trips on the next edge.
  - A fault shorter than DEBOUNCE_CYCLES never trips.
  - Reset mid-sequence or mid-trip always restarts POWER_UP from rail 0.
  - NUM_RAILS = 1: ON is entered STAGGER_CYCLES edges after entry.

Optional Feature:
AUTO_RESTART_EN:
- Defined:
  - In TRIPPED, a fault-free counter increments on each edge with no deb[i] high (masked or not), and clears otherwise.
  - When it reaches RESTART_CYCLES-1, the FSM enters POWER_UP exactly as for an accepted clear, except fault_latched is retained.
  - clear still works as before.
- Undefined:
  - No counter logic.
  - TRIPPED exits only via clear or reset.
  - RESTART_CYCLES is unused.

Decomposition:
- Package power_pkg holds:
  - state typedef and encodings (ST_POWER_UP, ST_ON, ST_TRIPPED)
  - a counter-width helper constant function
- One sub-module, fault_debounce:
  - per-fault saturating counter with output deb
  - instantiated NUM_FAULTS times with a generate loop
- FSM, stagger counter and latching stay in the top level.

Test Plan:
Bench parameters: NUM_FAULTS=2, NUM_RAILS=3, DEBOUNCE_CYCLES=4, STAGGER_CYCLES=8, RESTART_CYCLES=16.
1. Release reset, no faults → shutdown goes 111→110 at edge 8, 100 at edge 16, 000 at edge 24; all_on rises at edge 24; state=ON.
2. In ON, fault_in=01 held → shutdown=111 at the 5th edge after the first high sample; state=TRIPPED; fault_latched=01. A 3-cycle glitch causes no trip.
3. TRIPPED with fault_in[0] still high, pulse clear → ignored. Drop fault, pulse clear → POWER_UP, fault_latched=00, rail 0 released 8 edges later.
4. fault_mask=01, fault_in=01 for 20 cycles → no trip. Then fault_mask=00 → trip on the next edge.
5. Fault during POWER_UP after rail 0 released → all rails off the same edge. Trip and clear on the same edge → TRIPPED holds. Reset during TRIPPED → POWER_UP, shutdown=111.
6. With AUTO_RESTART_EN: trip, drop fault → POWER_UP 16 edges after the debounce clears, fault_latched retained. Without the macro → stays TRIPPED indefinitely.
